// File: rtl/rn_release_sequencer.sv
// Staged release of active-low bank resets, one bank per interval.
// Optional ack handshake per bank: define RN_SEQ_ACK_EN.
module rn_release_sequencer #(
  parameter int NUM_BANKS   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SW_RST,
`ifdef RN_SEQ_ACK_EN
  input  logic [NUM_BANKS-1:0] ACK,
`endif
  output logic [NUM_BANKS-1:0] RN,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int IDX_W = $clog2(NUM_BANKS);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_GAP      = 2'd1,
    S_IDLE     = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_BANKS-1:0] rn_q, rn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]     idx_nx;

  assign idx_nx = idx_q + 1'b1;

  // Next-state: count intervals and release banks in index order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rn_d    = rn_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (SW_RST) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rn_d    = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            rn_d[0] = 1'b1;
`ifdef RN_SEQ_ACK_EN
            state_d = S_WAIT_ACK;
`else
            state_d = S_GAP;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d        = '0;
            idx_d        = idx_nx;
            rn_d[idx_nx] = 1'b1;
`ifdef RN_SEQ_ACK_EN
            state_d = S_WAIT_ACK;
`else
            if (idx_nx == IDX_LAST) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_ACK: begin
`ifdef RN_SEQ_ACK_EN
          if (ACK[idx_q]) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_GAP;
            end
          end
`else
          state_d = S_IDLE;
`endif
        end
        S_IDLE: begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  // State registers with synchronous block reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rn_q    <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rn_q    <= rn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RN   = rn_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_rn_release_sequencer.sv
// Scoreboard bench for rn_release_sequencer, default and
// minimum-timing parameter sets driven from shared inputs.
module tb_rn_release_sequencer;

  localparam int N0 = 4;
  localparam int H0 = 8;
  localparam int G0 = 4;
  localparam int N1 = 2;
  localparam int H1 = 1;
  localparam int G1 = 1;

  typedef struct {
    logic [31:0] rn;
    logic        busy;
    logic        done;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SW_RST;
  logic [N0-1:0] rn0;
  logic          busy0;
  logic          done0;
  logic [N1-1:0] rn1;
  logic          busy1;
  logic          done1;

  exp_t q0[$];
  exp_t q1[$];
  int   e0;
  int   e1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  rn_release_sequencer #(
    .NUM_BANKS(N0), .HOLD_CYCLES(H0),
    .GAP_CYCLES(G0), .CNT_W(8)
  ) dut0 (
    .CLK(CLK), .RST(RST), .SW_RST(SW_RST),
    .RN(rn0), .BUSY(busy0), .DONE(done0)
  );

  rn_release_sequencer #(
    .NUM_BANKS(N1), .HOLD_CYCLES(H1),
    .GAP_CYCLES(G1), .CNT_W(4)
  ) dut1 (
    .CLK(CLK), .RST(RST), .SW_RST(SW_RST),
    .RN(rn1), .BUSY(busy1), .DONE(done1)
  );

  // Banks released after e clean edges since the last reset.
  function automatic int released(int e, int n, int h, int g);
    int r;
    if (e < h) return 0;
    r = (e - h) / g + 1;
    return (r > n) ? n : r;
  endfunction

  function automatic exp_t expect_of(int e, int n, int h, int g);
    exp_t x;
    int   k;
    k      = released(e, n, h, g);
    x.rn   = (32'h1 << k) - 32'h1;
    x.done = (k == n);
    x.busy = (k != n);
    return x;
  endfunction

  task automatic step(input logic r, input logic s);
    RST    = r;
    SW_RST = s;
    @(posedge CLK);
    if (r || s) begin
      e0 = 0;
      e1 = 0;
    end else begin
      if (e0 < 100000) e0 = e0 + 1;
      if (e1 < 100000) e1 = e1 + 1;
    end
    q0.push_back(expect_of(e0, N0, H0, G0));
    q1.push_back(expect_of(e1, N1, H1, G1));
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  // Monitor: compare every presented output against the queue.
  always @(negedge CLK) begin
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      chk("rn0", 32'(rn0), x.rn);
      chk("busy0", 32'(busy0), 32'(x.busy));
      chk("done0", 32'(done0), 32'(x.done));
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("rn1", 32'(rn1), x.rn);
      chk("busy1", 32'(busy1), 32'(x.busy));
      chk("done1", 32'(done1), 32'(x.done));
    end
  end

  initial begin
    e0 = 0;
    e1 = 0;
    RST = 1'b1;
    SW_RST = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (25) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    repeat (24) step(1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 49) == 0);
    end
    repeat (2) step(1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
